// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with enable and auto-scan.
// Direct mode latches a loaded address; scan mode dwells on each line.
module scan_decoder #(
  parameter int ADDR_WIDTH = 2,
  parameter int DWELL      = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       mode,
  input  logic                       load,
  input  logic [ADDR_WIDTH-1:0]      addr,
  output logic [2**ADDR_WIDTH-1:0]   out,
  output logic [ADDR_WIDTH-1:0]      cur_addr,
  output logic                       wrap
);

  localparam int NOUT = 2**ADDR_WIDTH;
  localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
  localparam logic [NOUT-1:0] ONE      = NOUT'(1);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NOUT-1:0]       out_q, out_d;
  logic                  wrap_q, wrap_d;

  logic dis, ld, dir, dw, st;
  logic [ADDR_WIDTH-1:0] addr_nx;

  // Mutually exclusive actions; load wins over any scan step.
  assign dis = ~enable;
  assign ld  = enable & load;
  assign dir = enable & ~load & ~mode;
  assign dw  = enable & ~load & mode & (cnt_q != CNT_LAST);
  assign st  = enable & ~load & mode & (cnt_q == CNT_LAST);

  assign addr_nx = addr_q + ADDR_WIDTH'(1);

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    out_d  = '0;
    wrap_d = 1'b0;
    unique case (1'b1)
      dis: begin
      end
      ld: begin
        addr_d = addr;
        cnt_d  = '0;
        out_d  = ONE << addr;
      end
      dir: begin
        cnt_d = '0;
        out_d = ONE << addr_q;
      end
      dw: begin
        cnt_d = cnt_q + CW'(1);
        out_d = ONE << addr_q;
      end
      st: begin
        addr_d = addr_nx;
        cnt_d  = '0;
        out_d  = ONE << addr_nx;
        wrap_d = (addr_q == '1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out      = out_q;
  assign cur_addr = addr_q;
  assign wrap     = wrap_q;

endmodule
